// File: rtl/led_seq_pkg.sv
// Shared mode codes, entry-value rules and blink divider limits for led_sequencer.
// BOUNCE mode is present only when LED_SEQ_BOUNCE_EN is defined.
package led_seq_pkg;

    localparam int unsigned MODE_W        = 2;
    localparam int unsigned BLINK_DIV_MAX = 15;
    localparam int unsigned BLINK_CNT_W   = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ENTRY_ZERO,
        ENTRY_ONES,
        ENTRY_LSB
    } entry_e;

    // Mode rotation on each mode request.
    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        case (m)
            MODE_UP:     n = MODE_DOWN;
`ifdef LED_SEQ_BOUNCE_EN
            MODE_DOWN:   n = MODE_BOUNCE;
            MODE_BOUNCE: n = MODE_BLINK;
`else
            MODE_DOWN:   n = MODE_BLINK;
            MODE_BOUNCE: n = MODE_BLINK;
`endif
            default:     n = MODE_UP;
        endcase
        return n;
    endfunction

    // LED value loaded when a mode is entered.
    function automatic entry_e entry_of(input mode_e m);
        entry_e e;
        case (m)
            MODE_DOWN:   e = ENTRY_ONES;
            MODE_BOUNCE: e = ENTRY_LSB;
            MODE_BLINK:  e = ENTRY_ONES;
            default:     e = ENTRY_ZERO;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to a configurable idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: UP/DOWN counters, optional BOUNCE (LED_SEQ_BOUNCE_EN) and BLINK,
// driven by a synchronized mode button and a pause button.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned BLINK_DIV = 1
) (
    input  logic             div_clk,
    input  logic             rst,
    input  logic             mode_btn,
    input  logic             pause_btn,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       mode,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] LED_LSB   = WIDTH'(1);
    localparam int unsigned      DIV_CLAMP = (BLINK_DIV < 32'd1) ? 32'd1 :
                                             (BLINK_DIV > BLINK_DIV_MAX) ? BLINK_DIV_MAX : BLINK_DIV;
    localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(DIV_CLAMP - 32'd1);

    logic                   w_mode_sync;
    logic                   w_pause_sync;
    logic                   w_press_mode;
    logic                   w_press_pause;
    logic                   w_mode_req;
    mode_e                  w_next_mode;
    logic [WIDTH-1:0]       w_entry_led;

    logic                   r_press_mode_d;
    logic [1:0]             r_settle;
    logic                   r_armed;
    mode_e                  r_mode;
    logic [WIDTH-1:0]       r_led;
    logic                   r_wrap;
    logic [BLINK_CNT_W-1:0] r_blink_cnt;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_mode (
        .clk (div_clk),
        .rst (rst),
        .d   (mode_btn),
        .q   (w_mode_sync)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_pause (
        .clk (div_clk),
        .rst (rst),
        .d   (pause_btn),
        .q   (w_pause_sync)
    );

    assign w_press_mode  = ~w_mode_sync;
    assign w_press_pause = ~w_pause_sync;
    // Requests need a release observed after the synchronizer has flushed, so a press held through reset is ignored.
    assign w_mode_req    = w_press_mode & ~r_press_mode_d & r_armed;
    assign w_next_mode   = next_mode(r_mode);

    always_comb begin
        w_entry_led = '0;
        case (entry_of(w_next_mode))
            ENTRY_ONES: w_entry_led = ALL_ONES;
            ENTRY_LSB:  w_entry_led = LED_LSB;
            default:    w_entry_led = '0;
        endcase
    end

`ifdef LED_SEQ_BOUNCE_EN
    logic             r_dir_left;
    logic [WIDTH-1:0] w_bounce_led;
    logic             w_bounce_left;
    logic             w_bounce_wrap;

    // One-hot walk that turns around at either end without dwelling.
    always_comb begin
        w_bounce_led  = r_led;
        w_bounce_left = r_dir_left;
        if (WIDTH > 1) begin
            if (r_dir_left) begin
                if (r_led[WIDTH-1]) begin
                    w_bounce_led  = r_led >> 1;
                    w_bounce_left = 1'b0;
                end else begin
                    w_bounce_led  = r_led << 1;
                end
            end else begin
                if (r_led[0]) begin
                    w_bounce_led  = r_led << 1;
                    w_bounce_left = 1'b1;
                end else begin
                    w_bounce_led  = r_led >> 1;
                end
            end
        end
    end

    assign w_bounce_wrap = (w_bounce_led == LED_LSB) && (r_led != LED_LSB);
`endif

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            r_press_mode_d <= 1'b0;
            r_settle       <= 2'd0;
            r_armed        <= 1'b0;
            r_mode         <= MODE_UP;
            r_led          <= '0;
            r_wrap         <= 1'b0;
            r_blink_cnt    <= '0;
`ifdef LED_SEQ_BOUNCE_EN
            r_dir_left     <= 1'b1;
`endif
        end else begin
            r_press_mode_d <= w_press_mode;
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end
            if ((r_settle == 2'd2) && !w_press_mode) begin
                r_armed <= 1'b1;
            end
            r_wrap <= 1'b0;

            if (w_mode_req) begin
                r_mode      <= w_next_mode;
                r_led       <= w_entry_led;
                r_blink_cnt <= '0;
`ifdef LED_SEQ_BOUNCE_EN
                r_dir_left  <= 1'b1;
`endif
            end else if (!w_press_pause) begin
                case (r_mode)
                    MODE_UP: begin
                        r_led  <= r_led + LED_LSB;
                        r_wrap <= (r_led == ALL_ONES);
                    end
                    MODE_DOWN: begin
                        r_led  <= r_led - LED_LSB;
                        r_wrap <= (r_led == '0);
                    end
`ifdef LED_SEQ_BOUNCE_EN
                    MODE_BOUNCE: begin
                        r_led      <= w_bounce_led;
                        r_dir_left <= w_bounce_left;
                        r_wrap     <= w_bounce_wrap;
                    end
`endif
                    MODE_BLINK: begin
                        if (r_blink_cnt == BLINK_LAST) begin
                            r_led       <= ~r_led;
                            r_blink_cnt <= '0;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BLINK_CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign led  = r_led;
    assign mode = r_mode;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (WIDTH=4; BLINK_DIV=1 and BLINK_DIV=3 instances).
// Builds with or without LED_SEQ_BOUNCE_EN.
`timescale 1ns/1ps
module tb_led_sequencer;

    localparam int W    = 4;
    localparam int MASK = 15;

    logic       div_clk = 1'b0;
    logic       rst;
    logic       mode_btn;
    logic       pause_btn;
    logic [3:0] led1, led3;
    logic [1:0] mode1, mode3;
    logic       wrap1, wrap3;

    int n_vec = 0;
    int n_err = 0;

    led_sequencer #(.WIDTH(4), .BLINK_DIV(1)) u_dut (
        .div_clk   (div_clk),
        .rst       (rst),
        .mode_btn  (mode_btn),
        .pause_btn (pause_btn),
        .led       (led1),
        .mode      (mode1),
        .wrap      (wrap1)
    );

    led_sequencer #(.WIDTH(4), .BLINK_DIV(3)) u_dut3 (
        .div_clk   (div_clk),
        .rst       (rst),
        .mode_btn  (mode_btn),
        .pause_btn (pause_btn),
        .led       (led3),
        .mode      (mode3),
        .wrap      (wrap3)
    );

    always #5 div_clk = ~div_clk;

`ifdef LED_SEQ_BOUNCE_EN
    localparam int NMODES = 4;
    int mode_seq [NMODES] = '{0, 1, 2, 3};
`else
    localparam int NMODES = 3;
    int mode_seq [NMODES] = '{0, 1, 3};
`endif

    // Reference model: mode index into the rotation, led value and a phase counter since mode entry.
    typedef struct {
        int mi;
        int led;
        int k;
        bit wrap;
    } mstate_t;

    mstate_t m1, m3;
    bit      qm[$];
    bit      qp[$];

    function automatic int entry_led(input int code);
        case (code)
            0:       return 0;
            2:       return 1;
            default: return MASK;
        endcase
    endfunction

    function automatic int bounce_led(input int k);
        int p;
        p = (k < W) ? k : (2 * W - 2 - k);
        return 1 << p;
    endfunction

    function automatic mstate_t step(input mstate_t s, input bit req, input bit pz, input int div);
        mstate_t n;
        int      code;
        n      = s;
        code   = mode_seq[s.mi];
        n.wrap = 1'b0;
        if (req) begin
            n.mi  = (s.mi + 1) % NMODES;
            n.led = entry_led(mode_seq[n.mi]);
            n.k   = 0;
        end else if (!pz) begin
            case (code)
                0: begin
                    n.wrap = (s.led == MASK);
                    n.led  = (s.led + 1) & MASK;
                end
                1: begin
                    n.wrap = (s.led == 0);
                    n.led  = (s.led - 1) & MASK;
                end
                2: begin
                    n.k    = (s.k + 1) % (2 * W - 2);
                    n.led  = bounce_led(n.k);
                    n.wrap = (n.k == 0);
                end
                default: begin
                    n.k   = (s.k + 1) % (2 * div);
                    n.led = (((n.k / div) % 2) == 0) ? MASK : 0;
                end
            endcase
        end
        return n;
    endfunction

    // Button effect appears two samples late; a request needs a real post-reset high-then-low pair.
    always @(posedge div_clk or posedge rst) begin : model
        int sz;
        bit req;
        bit pz;
        if (rst) begin
            m1 = '{mi: 0, led: 0, k: 0, wrap: 1'b0};
            m3 = '{mi: 0, led: 0, k: 0, wrap: 1'b0};
            qm.delete();
            qp.delete();
        end else begin
            sz  = qm.size();
            req = (sz >= 3) && qm[sz-3] && !qm[sz-2];
            pz  = (sz >= 2) && !qp[sz-2];
            m1  = step(m1, req, pz, 1);
            m3  = step(m3, req, pz, 3);
            qm.push_back(mode_btn);
            qp.push_back(pause_btn);
            if (qm.size() > 4) begin
                void'(qm.pop_front());
                void'(qp.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge div_clk);
    endtask

    task automatic press_mode();
        mode_btn = 1'b0;
        repeat (3) @(negedge div_clk);
        mode_btn = 1'b1;
        repeat (3) @(negedge div_clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mode_btn  = 1'b1;
        pause_btn = 1'b1;
        repeat (2) @(negedge div_clk);
        n_vec++;
        if (led1 !== 4'h0 || mode1 !== 2'd0 || wrap1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got led=%h mode=%0d wrap=%b want led=0 mode=0 wrap=0", led1, mode1, wrap1);
        end
        n_vec++;
        if (led3 !== 4'h0 || mode3 !== 2'd0 || wrap3 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state3: got led=%h mode=%0d wrap=%b want led=0 mode=0 wrap=0", led3, mode3, wrap3);
        end
        rst = 1'b0;
    endtask

    task automatic test_up_count();
        for (int i = 0; i < 16; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (led1 !== 4'((i + 1) % 16) || wrap1 !== (i == 15)) begin
                n_err++;
                $display("FAIL up_count[%0d]: got led=%h wrap=%b want led=%h wrap=%b",
                         i, led1, wrap1, 4'((i + 1) % 16), (i == 15));
            end
        end
    endtask

    task automatic test_mode_press();
        logic [3:0] exp_after [2] = '{4'hE, 4'hD};
        mode_btn = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (i < 3 && mode1 !== 2'd0) begin
                n_err++;
                $display("FAIL mode_latency[%0d]: got mode=%0d want 0", i, mode1);
            end else if (i == 3 && (mode1 !== 2'd1 || led1 !== 4'hF || wrap1 !== 1'b0)) begin
                n_err++;
                $display("FAIL mode_entry_down: got mode=%0d led=%h wrap=%b want mode=1 led=f wrap=0", mode1, led1, wrap1);
            end
        end
        mode_btn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (led1 !== exp_after[i]) begin
                n_err++;
                $display("FAIL down_count[%0d]: got led=%h want %h", i, led1, exp_after[i]);
            end
        end
    endtask

`ifdef LED_SEQ_BOUNCE_EN
    task automatic test_bounce();
        logic [3:0] exp_led [7] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        mode_btn = 1'b0;
        idle(3);
        n_vec++;
        if (mode1 !== 2'd2 || led1 !== 4'h1 || wrap1 !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_entry: got mode=%0d led=%h wrap=%b want mode=2 led=1 wrap=0", mode1, led1, wrap1);
        end
        mode_btn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (led1 !== exp_led[i] || wrap1 !== (i == 5) || !$onehot(led1)) begin
                n_err++;
                $display("FAIL bounce[%0d]: got led=%h wrap=%b want led=%h wrap=%b", i, led1, wrap1, exp_led[i], (i == 5));
            end
        end
    endtask
`else
    task automatic test_mode_cycle();
        logic [1:0] exp_mode [2] = '{2'd3, 2'd0};
        for (int i = 0; i < 2; i++) begin
            mode_btn = 1'b0;
            idle(3);
            n_vec++;
            if (mode1 !== exp_mode[i]) begin
                n_err++;
                $display("FAIL mode_cycle[%0d]: got mode=%0d want %0d", i, mode1, exp_mode[i]);
            end
            mode_btn = 1'b1;
            idle(3);
        end
    endtask
`endif

    task automatic test_blink();
        logic [3:0] exp3 [7] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
        logic [3:0] exp1 [7] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
        int guard = 0;
        while (mode_seq[m1.mi] != mode_seq[NMODES-2] && guard < 4) begin
            press_mode();
            guard++;
        end
        n_vec++;
        if (mode_seq[m1.mi] != mode_seq[NMODES-2]) begin
            n_err++;
            $display("FAIL blink_setup: got mode=%0d want %0d", mode1, mode_seq[NMODES-2]);
        end
        mode_btn = 1'b0;
        idle(3);
        for (int i = 0; i < 7; i++) begin
            if (i == 1) mode_btn = 1'b1;
            if (i > 0) @(negedge div_clk);
            n_vec++;
            if (mode3 !== 2'd3 || led3 !== exp3[i] || wrap3 !== 1'b0) begin
                n_err++;
                $display("FAIL blink_div3[%0d]: got mode=%0d led=%h wrap=%b want mode=3 led=%h wrap=0",
                         i, mode3, led3, wrap3, exp3[i]);
            end
            n_vec++;
            if (led1 !== exp1[i] || wrap1 !== 1'b0) begin
                n_err++;
                $display("FAIL blink_div1[%0d]: got led=%h wrap=%b want led=%h wrap=0", i, led1, wrap1, exp1[i]);
            end
        end
    endtask

    task automatic test_mode_over_pause();
        mode_btn  = 1'b0;
        pause_btn = 1'b0;
        idle(3);
        n_vec++;
        if (mode1 !== 2'd0 || led1 !== 4'h0 || wrap1 !== 1'b0) begin
            n_err++;
            $display("FAIL mode_over_pause: got mode=%0d led=%h wrap=%b want mode=0 led=0 wrap=0", mode1, led1, wrap1);
        end
        mode_btn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) pause_btn = 1'b1;
            @(negedge div_clk);
            n_vec++;
            if (mode1 !== 2'd0 || led1 !== 4'h0) begin
                n_err++;
                $display("FAIL held_after_entry[%0d]: got mode=%0d led=%h want mode=0 led=0", i, mode1, led1);
            end
        end
        @(negedge div_clk);
        n_vec++;
        if (led1 !== 4'h1) begin
            n_err++;
            $display("FAIL resume_after_entry: got led=%h want 1", led1);
        end
    endtask

    task automatic test_pause();
        int guard = 0;
        while (m1.led != 4 && guard < 40) begin
            @(negedge div_clk);
            guard++;
        end
        n_vec++;
        if (led1 !== 4'h4) begin
            n_err++;
            $display("FAIL pause_setup: got led=%h want 4", led1);
        end
        pause_btn = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (led1 !== ((i == 0) ? 4'h5 : 4'h6) || wrap1 !== 1'b0) begin
                n_err++;
                $display("FAIL pause_hold[%0d]: got led=%h wrap=%b want led=%h wrap=0",
                         i, led1, wrap1, (i == 0) ? 4'h5 : 4'h6);
            end
        end
        pause_btn = 1'b1;
        idle(2);
        n_vec++;
        if (led1 !== 4'h6) begin
            n_err++;
            $display("FAIL pause_release_latency: got led=%h want 6", led1);
        end
        @(negedge div_clk);
        n_vec++;
        if (led1 !== 4'h7) begin
            n_err++;
            $display("FAIL pause_release: got led=%h want 7", led1);
        end
    endtask

    task automatic test_reset_mid();
        idle(3);
        rst = 1'b1;
        #1;
        n_vec++;
        if (led1 !== 4'h0 || mode1 !== 2'd0 || wrap1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got led=%h mode=%0d wrap=%b want led=0 mode=0 wrap=0", led1, mode1, wrap1);
        end
        @(negedge div_clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (led1 !== 4'(i + 1) || wrap1 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release[%0d]: got led=%h wrap=%b want led=%h wrap=0", i, led1, wrap1, 4'(i + 1));
            end
        end
    endtask

    task automatic test_held_through_reset();
        mode_btn = 1'b0;
        rst      = 1'b1;
        @(negedge div_clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (mode1 !== 2'd0 || led1 !== 4'(m1.led)) begin
                n_err++;
                $display("FAIL held_through_reset[%0d]: got mode=%0d led=%h want mode=0 led=%h",
                         i, mode1, led1, 4'(m1.led));
            end
        end
        mode_btn = 1'b1;
        idle(3);
        mode_btn = 1'b0;
        idle(3);
        n_vec++;
        if (mode1 !== 2'd1 || led1 !== 4'hF) begin
            n_err++;
            $display("FAIL press_after_held: got mode=%0d led=%h want mode=1 led=f", mode1, led1);
        end
        mode_btn = 1'b1;
        idle(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge div_clk);
            n_vec++;
            if (led1 !== 4'(m1.led) || mode1 !== 2'(mode_seq[m1.mi]) || wrap1 !== m1.wrap) begin
                n_err++;
                $display("FAIL random[%0d]: got led=%h mode=%0d wrap=%b want led=%h mode=%0d wrap=%b",
                         i, led1, mode1, wrap1, 4'(m1.led), mode_seq[m1.mi], m1.wrap);
            end
            n_vec++;
            if (led3 !== 4'(m3.led) || mode3 !== 2'(mode_seq[m3.mi]) || wrap3 !== m3.wrap) begin
                n_err++;
                $display("FAIL random3[%0d]: got led=%h mode=%0d wrap=%b want led=%h mode=%0d wrap=%b",
                         i, led3, mode3, wrap3, 4'(m3.led), mode_seq[m3.mi], m3.wrap);
            end
            if (mode1 === 2'd2) begin
                n_vec++;
                if (!$onehot(led1)) begin
                    n_err++;
                    $display("FAIL random_onehot[%0d]: got led=%h want one-hot", i, led1);
                end
            end
            if ($urandom_range(0, 7) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 9) == 0) pause_btn = ~pause_btn;
            rst = ($urandom_range(0, 99) == 0);
        end
        rst       = 1'b0;
        mode_btn  = 1'b1;
        pause_btn = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        mode_btn  = 1'b1;
        pause_btn = 1'b1;
        test_reset();
        test_up_count();
        test_mode_press();
`ifdef LED_SEQ_BOUNCE_EN
        test_bounce();
`else
        test_mode_cycle();
`endif
        test_blink();
        test_mode_over_pause();
        test_pause();
        test_reset_mid();
        test_held_through_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
